// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/main-memory arbiter.
// The watchdog default here applies only to builds with ARB_TIMEOUT_EN defined.
package cache_arb_pkg;

    localparam int NUM_REQ                = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } arb_op_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Requester and main-memory signals of the cache/memory arbiter.
// The arbiter uses the master view; the surrounding caches and memory use the slave view.
interface cache_mem_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int BLOCK_W = 128
) ();

    logic [NUM_REQ-1:0]         req_rd;
    logic [NUM_REQ-1:0]         req_wr;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*BLOCK_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]         req_done;
    logic [BLOCK_W-1:0]         req_rdata;
    logic [NUM_REQ-1:0]         req_err;

    logic                       mem_rd_en;
    logic                       mem_wr_en;
    logic [ADDR_W-1:0]          mem_addr;
    logic [BLOCK_W-1:0]         mem_wdata;
    logic [BLOCK_W-1:0]         mem_rdata;
    logic                       mem_ready;

    modport master (
        input  req_rd, req_wr, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_done, req_rdata, req_err, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        output req_rd, req_wr, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_done, req_rdata, req_err, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_arb_rr.sv
// Combinational round-robin picker for two requesters: a tie goes to the
// requester that was not granted last.
module cache_arb_rr
    import cache_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] active,
    input  logic               last_grant,
    output logic               grant_valid,
    output logic               grant_id
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        grant_valid = |active;
        grant_id    = 1'b0;
        case (active)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between the I-cache (0)
// and D-cache (1). Optional watchdog abort is enabled with `define ARB_TIMEOUT_EN.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int BLOCK_W        = 128,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.master bus
);

    arb_state_t         state_q, state_d;
    logic               last_grant_q;
    logic               grant_q;
    arb_op_t            op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic [BLOCK_W-1:0] rdata_q;

    logic [NUM_REQ-1:0] active;
    logic               grant_valid;
    logic               grant_id;
    logic               load;
    logic               capture;
    logic               timeout;

    // A requester with both read and write raised is still a single active request.
    assign active = bus.req_rd | bus.req_wr;

    cache_arb_rr u_rr (
        .active      (active),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mem_ready) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            if (capture || timeout)
                last_grant_q <= grant_q;
        end
    end

    // NOTE: the latched request is reset as well, so mem_addr/mem_wdata/req_rdata read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= 1'b0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (load) begin
                grant_q <= grant_id;
                op_q    <= bus.req_wr[grant_id] ? OP_WR : OP_RD;
                addr_q  <= bus.req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
                wdata_q <= bus.req_wdata[int'(grant_id)*BLOCK_W +: BLOCK_W];
            end
            // Writes leave the last read block visible on req_rdata.
            if (capture && op_q == OP_RD)
                rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.mem_rd_en = (state_q == ISSUE || state_q == WAIT) && op_q == OP_RD;
    assign bus.mem_wr_en = (state_q == ISSUE || state_q == WAIT) && op_q == OP_WR;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.req_rdata = rdata_q;
    assign bus.req_done  = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]   wait_cnt_q;
    logic [NUM_REQ-1:0] err_q;

    // Abort after TIMEOUT_CYCLES WAIT cycles; a mem_ready in the final cycle still completes.
    assign timeout = (state_q == WAIT) && !bus.mem_ready
                     && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            if (state_q == ISSUE)
                wait_cnt_q <= '0;
            else if (state_q == WAIT)
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            err_q <= timeout ? (NUM_REQ'(1) << grant_q) : '0;
        end
    end

    assign bus.req_err = err_q;
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
    assign bus.req_err           = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized self-checking bench for cache_mem_arbiter against a transaction-level
// model of the two requesters, the memory and the round-robin grant order.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int BLOCK_W = 128;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = DEFAULT_TIMEOUT_CYCLES;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

    cache_mem_arbiter #(
        .ADDR_W         (ADDR_W),
        .BLOCK_W        (BLOCK_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Requester model: a pending block transfer per cache.
    bit                 pend[2], pend_rd[2], pend_wr[2], drop_next[2], line_off[2];
    logic [ADDR_W-1:0]  p_addr[2];
    logic [BLOCK_W-1:0] p_wdata[2];

    // The one transaction in flight: granted in cycle g, enable from g+1 to t_ready, done at t_ready+1.
    bit                 t_valid = 0;
    int                 t_id, t_issue, t_ready;
    bit                 t_wr;
    logic [ADDR_W-1:0]  t_addr;
    logic [BLOCK_W-1:0] t_wdata, t_rdata;
    int                 free_cyc    = 0;
    int                 last_served = 1;
    logic [BLOCK_W-1:0] last_rdata  = '0;

    bit                 rnd_mode = 0, sat_mode = 0, use_fixed_rdata = 0;
    int                 sat_left = 0, fixed_delay = 0;
    logic [BLOCK_W-1:0] fixed_rdata;
    int                 done_log[$];

    task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [BLOCK_W-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue(input int i, input bit rd, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
        pend[i]    = 1;
        pend_rd[i] = rd;
        pend_wr[i] = wr;
        p_addr[i]  = a;
        p_wdata[i] = d;
    endtask

    task automatic new_req(input int i);
        int k;
        k = $urandom_range(0, 3);
        issue(i, k != 1, k == 1 || k == 2, $urandom & 32'hFFFF_FFF0, rand_block());
        if (sat_mode) sat_left--;
    endtask

    task automatic clear_lines();
        bus.req_rd    = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    // One clock cycle: check the DUT outputs of this cycle, then drive this cycle's inputs.
    task automatic step();
        bit       in_win;
        bit [1:0] act;
        logic [1:0] exp_done;
        int       g;
        @(negedge clk);
        cyc++;
        in_win = t_valid && cyc >= t_issue && cyc <= t_ready;
        check("mem_rd_en", bus.mem_rd_en, in_win && !t_wr);
        check("mem_wr_en", bus.mem_wr_en, in_win && t_wr);
        if (in_win) begin
            check("mem_addr", bus.mem_addr, t_addr);
            if (t_wr) check("mem_wdata", bus.mem_wdata, t_wdata);
        end
        exp_done = (t_valid && cyc == t_ready + 1) ? (2'b01 << t_id) : 2'b00;
        check("req_done", bus.req_done, exp_done);
        check("req_err", bus.req_err, 2'b00);
        if (bus.req_done != 2'b00) done_log.push_back(bus.req_done[1] ? 1 : 0);
        if (exp_done != 2'b00) begin
            check("req_rdata", bus.req_rdata, t_wr ? last_rdata : t_rdata);
            if (!t_wr) last_rdata = t_rdata;
            last_served  = t_id;
            pend[t_id]   = 0;
            drop_next[t_id] = 1;
            t_valid      = 0;
            free_cyc     = cyc + 1;
        end

        // Memory: complete at the planned cycle; stray ready pulses only outside WAIT.
        bus.mem_ready = 1'b0;
        bus.mem_rdata = rand_block();
        if (t_valid && cyc == t_ready) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = t_rdata;
        end else if (rnd_mode && !(t_valid && cyc > t_issue && cyc <= t_ready)
                     && $urandom_range(0, 7) == 0) begin
            bus.mem_ready = 1'b1;
        end

        for (int i = 0; i < 2; i++) begin
            if (drop_next[i]) begin
                drop_next[i] = 0;
                line_off[i]  = 0;
            end else if (!pend[i] && ((sat_mode && sat_left > 0) || (rnd_mode && $urandom_range(0, 2) == 0))) begin
                new_req(i);
            end else if (rnd_mode && pend[i] && t_valid && t_id == i && cyc > t_issue
                         && $urandom_range(0, 3) == 0) begin
                line_off[i] = 1;
            end
            bus.req_rd[i] = pend[i] && !line_off[i] && pend_rd[i];
            bus.req_wr[i] = pend[i] && !line_off[i] && pend_wr[i];
            bus.req_addr[i*ADDR_W +: ADDR_W]    = p_addr[i];
            bus.req_wdata[i*BLOCK_W +: BLOCK_W] = p_wdata[i];
        end

        if (!t_valid && cyc >= free_cyc) begin
            act = {bus.req_rd[1] | bus.req_wr[1], bus.req_rd[0] | bus.req_wr[0]};
            if (act != 2'b00) begin
                g        = (act == 2'b11) ? 1 - last_served : (act[1] ? 1 : 0);
                t_valid  = 1;
                t_id     = g;
                t_wr     = bus.req_wr[g];
                t_addr   = p_addr[g];
                t_wdata  = p_wdata[g];
                t_issue  = cyc + 1;
                t_ready  = t_issue + ((fixed_delay > 0) ? fixed_delay : $urandom_range(1, 4));
                t_rdata  = use_fixed_rdata ? fixed_rdata : rand_block();
            end
        end
    endtask

    task automatic run_until_quiet(input int max_cycles);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((t_valid || pend[0] || pend[1] || drop_next[0] || drop_next[1] || sat_left > 0)
                   && n < max_cycles);
        check("quiet_in_budget", {t_valid, pend[0], pend[1], sat_left > 0}, 4'b0000);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_rd_en"}, bus.mem_rd_en, 1'b0);
        check({tag, "_mem_wr_en"}, bus.mem_wr_en, 1'b0);
        check({tag, "_mem_addr"}, bus.mem_addr, '0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
        check({tag, "_req_done"}, bus.req_done, 2'b00);
        check({tag, "_req_rdata"}, bus.req_rdata, '0);
        check({tag, "_req_err"}, bus.req_err, 2'b00);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; drop_next[i] = 0; line_off[i] = 0;
        end
        t_valid     = 0;
        free_cyc    = 0;
        last_served = 1;
        last_rdata  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_lines();
        reset_model();

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Tie straight after reset: requester 0 first, then 1.
        done_log.delete();
        issue(0, 1, 0, 32'h0000_0100, '0);
        issue(1, 1, 0, 32'h0000_0200, '0);
        run_until_quiet(40);
        check("tie_count", done_log.size(), 2);
        if (done_log.size() == 2) begin
            check("tie_first", done_log[0], 0);
            check("tie_second", done_log[1], 1);
        end

        // Single read with memory answering 4 cycles after the enable rises.
        fixed_delay     = 4;
        use_fixed_rdata = 1;
        fixed_rdata     = 128'hDEADBEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
        issue(0, 1, 0, 32'h0000_0040, '0);
        run_until_quiet(30);
        use_fixed_rdata = 0;
        fixed_delay     = 0;

        // Read and write raised together: served as a write.
        issue(1, 1, 1, 32'h0000_0080, 128'h1234_5678_9ABC_DEF0_1122_3344_5566_7788);
        run_until_quiet(30);

        // Saturation: both caches re-request as soon as allowed; grants alternate.
        done_log.delete();
        sat_mode = 1;
        sat_left = 10;
        run_until_quiet(200);
        sat_mode = 0;
        check("sat_count", done_log.size(), 10);
        for (int k = 0; k < done_log.size(); k++) check("sat_order", done_log[k], k % 2);

        // Randomized traffic with stray ready pulses and mid-transaction drops.
        rnd_mode = 1;
        repeat (600) step();
        rnd_mode = 0;
        run_until_quiet(60);

        // Reset in the middle of WAIT.
        fixed_delay = 8;
        issue(0, 1, 0, 32'h0000_01C0, '0);
        begin
            int n;
            n = 0;
            while (!bus.mem_rd_en && n < 10) begin
                step();
                n++;
            end
            check("rd_en_before_reset", bus.mem_rd_en, 1'b1);
        end
        step();
        step();
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        reset_model();
        clear_lines();
        repeat (3) begin
            @(negedge clk);
            check("in_reset_req_done", bus.req_done, 2'b00);
            check("in_reset_mem_rd_en", bus.mem_rd_en, 1'b0);
        end
        rst = 1'b1;
        fixed_delay = 0;
        done_log.delete();
        issue(0, 1, 0, 32'h0000_0300, '0);
        issue(1, 0, 1, 32'h0000_0400, rand_block());
        run_until_quiet(40);
        check("post_reset_count", done_log.size(), 2);
        if (done_log.size() > 0) check("post_reset_first", done_log[0], 0);

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: requester 0 gets an error, then requester 1 is served.
        begin
            int n;
            @(negedge clk);
            clear_lines();
            bus.req_rd = 2'b01;
            bus.req_addr[0 +: ADDR_W] = 32'h0000_0500;
            bus.req_addr[ADDR_W +: ADDR_W] = 32'h0000_0600;
            n = 0;
            while (!bus.mem_rd_en && n < 10) begin
                @(negedge clk);
                n++;
            end
            bus.req_rd = 2'b11;
            n = 0;
            while (bus.req_err == 2'b00 && n < 40) begin
                check("tmo_no_done", bus.req_done, 2'b00);
                @(negedge clk);
                n++;
            end
            check("tmo_err", bus.req_err, 2'b01);
            check("tmo_rd_en_dropped", bus.mem_rd_en, 1'b0);
            check("tmo_no_done_at_err", bus.req_done, 2'b00);
            bus.req_rd = 2'b10;
            @(negedge clk);
            check("tmo_err_single_pulse", bus.req_err, 2'b00);
            n = 0;
            while (!bus.mem_rd_en && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("tmo_next_rd_en", bus.mem_rd_en, 1'b1);
            check("tmo_next_addr", bus.mem_addr, 32'h0000_0600);
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
            @(negedge clk);
            check("tmo_next_done", bus.req_done, 2'b10);
            clear_lines();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory block port between two cache controllers: requester 0 (I-cache) and requester 1 (D-cache).
- Each requester issues block reads (refill) or block writes (dirty write-back) and holds until done.
- Arbitration is round-robin; exactly one memory transaction is outstanding at a time.
- Sits between the cache controllers and main memory inside the cache top level.

Parameters:
- ADDR_W, 32, block-aligned address width.
- BLOCK_W, 128, block data width; equals `BLOCK_SIZE`.
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- req_rd  input  2  per-requester block-read request; bit i = requester i.
- req_wr  input  2  per-requester block-write request.
- req_addr  input  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  2*BLOCK_W  requester i write-back block.
- req_done  output  2  one-cycle completion pulse per requester.
- req_rdata  output  BLOCK_W  read block; valid only while req_done is asserted.
- req_err  output  2  timeout-abort pulse (optional feature; tied 0 otherwise).
- mem_rd_en  output  1  memory read enable.
- mem_wr_en  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  BLOCK_W  memory write block.
- mem_rdata  input  BLOCK_W  memory read block; valid with mem_ready.
- mem_ready  input  1  one-cycle memory completion pulse.

Behaviour:
- Reset (rst=0, async): state IDLE; last_grant=1; all outputs 0, including mem_*, req_done, req_rdata and req_err.
- Reset mid-transaction abandons it; no done is issued.
- A requester is active when req_rd[i] | req_wr[i].
- If both req_rd[i] and req_wr[i] are set, write wins and is served as a write.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - One requester active: grant it.
  - Both active: grant the one not equal to last_grant.
  - On grant, latch grant id, op, addr and wdata; go to ISSUE.
  - No requester active: stay in IDLE.
- ISSUE (one cycle): drive mem_rd_en or mem_wr_en together with mem_addr and mem_wdata from the latched values; go to WAIT.
- WAIT:
  - Hold enables and address/data stable.
  - On mem_ready: capture mem_rdata (reads), drop enables, update last_grant, go to RESP.
- RESP (one cycle):
  - req_done[grant]=1.
  - For reads, req_rdata = captured block.
  - For writes, req_rdata holds its previous value.
  - Next state is IDLE.
- Latency: request seen in cycle N gives enable asserted in cycle N+1. mem_ready in cycle M gives req_done in cycle M+1. Minimum total is 3 cycles.
- Requester obligations:
  - Hold the request and its address/data until req_done.
  - Deassert the request in the cycle after req_done; it is not re-sampled before then.
- Dropping a request mid-transaction is ignored; the transaction completes and req_done still pulses.
- mem_ready outside WAIT is ignored.
- Requests from the non-granted requester are held off until the next IDLE; no starvation, because ties always alternate.
- req_done is never asserted to both requesters in the same cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter resets on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without mem_ready: drop enables, pulse req_err[grant] for one cycle (no req_done), update last_grant, return to IDLE.
  - If mem_ready arrives on the same cycle as the limit, mem_ready wins.
- When undefined: no counter; WAIT is held indefinitely; req_err is constant 0.

Decomposition:
- Package cache_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, RESP}.
  - op enum {OP_RD, OP_WR}.
  - NUM_REQ=2.
  - Default TIMEOUT_CYCLES.
- Sub-module cache_arb_rr: combinational round-robin picker. Inputs active[1:0] and last_grant; outputs grant_valid and grant_id. Instantiated once.

Test Plan:
- Single read: req_rd=01, addr0=0x0000_0040; mem_ready 4 cycles after mem_rd_en with mem_rdata=0xDEADBEEF_...; expect mem_addr=0x40, req_done=01 the cycle after mem_ready, req_rdata matches.
- Tie after reset: req_rd=11 at the same cycle; requester 0 is served first, then requester 1 without returning to it. Total two req_done pulses, in order 01 then 10.
- Write priority: req_rd[1]=req_wr[1]=1, addr1=0x80, wdata1=0x1234...; expect mem_wr_en=1, mem_rd_en=0, mem_wdata=wdata1.
- Fairness under saturation: both requesters continuously active for 10 transactions; grants alternate 0,1,0,1,… with no double-serve.
- Reset mid-WAIT: assert rst=0 while mem_rd_en=1; all outputs are 0 immediately, no req_done follows, and after release the next tie goes to requester 0.
- ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, mem_ready never asserted: req_err[grant] pulses once, enables drop, and the other pending requester is served next.
